// File: rtl/shifter_arb_pkg.sv
// rtl/shifter_arb_pkg.sv - shared types and helpers for the shifter round-robin arbiter
package shifter_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_REL  = 2'd3
   } arb_state_t;

   localparam int N_MIN = 2;
   localparam int N_MAX = 16;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic bit n_in_range(input int n);
      return (n >= N_MIN) && (n <= N_MAX);
   endfunction

endpackage

// File: rtl/hs_sync.sv
// rtl/hs_sync.sv - multi-stage input synchroniser with bypass when STAGES is zero
module hs_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (STAGES == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ reset;
         assign q = d;
      end else begin : g_sync
         logic [W-1:0] stg [STAGES];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < STAGES; i++) stg[i] <= '0;
            end else begin
               stg[0] <= d;
               for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
            end
         end

         assign q = stg[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/shifter_rr_arbiter.sv
// rtl/shifter_rr_arbiter.sv - round-robin arbiter sharing one four-phase resource among N clients
module shifter_rr_arbiter
   import shifter_arb_pkg::*;
#(
   parameter int N           = 4,
   parameter int DATA_W      = 8,
   parameter int RES_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N-1:0]          req_i,
   output logic [N-1:0]          ack_o,
   input  logic [N*DATA_W-1:0]   req_data_i,
   output logic [RES_W-1:0]      result_o,
   output logic                  res_req_o,
   input  logic                  res_ack_i,
   output logic [DATA_W-1:0]     res_data_o,
   input  logic [RES_W-1:0]      res_result_i,
   output logic [idx_w(N)-1:0]   sel_o,
   output logic                  busy_o,
   output logic                  proto_err_o
);

   localparam int IW = idx_w(N);

   generate
      if (!n_in_range(N)) begin : g_bad_n
         $error("shifter_rr_arbiter: N must be within 2..16");
      end
   endgenerate

   logic [N-1:0]  req_s;
   logic          res_ack_s;
   arb_state_t    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] winner;
   logic          err_seen;

   hs_sync #(.W(N), .STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .reset (reset),
      .d     (req_i),
      .q     (req_s)
   );

   hs_sync #(.W(1), .STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .reset (reset),
      .d     (res_ack_i),
      .q     (res_ack_s)
   );

   // First requester found scanning cyclically from the pointer.
   function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
      logic [IW-1:0] w;
      logic          found;
      int            j;
      w     = p;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = (int'(p) + i) % N;
         if (!found && r[j]) begin
            w     = IW'(j);
            found = 1'b1;
         end
      end
      return w;
   endfunction

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] s);
      return (s == IW'(N - 1)) ? '0 : s + 1'b1;
   endfunction

   assign winner = rr_pick(req_s, ptr);
   assign busy_o = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         sel_o       <= '0;
         res_data_o  <= '0;
         res_req_o   <= 1'b0;
         ack_o       <= '0;
         result_o    <= '0;
         proto_err_o <= 1'b0;
         err_seen    <= 1'b0;
      end else begin
         proto_err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req_s) begin
                  sel_o      <= winner;
                  res_data_o <= req_data_i[winner*DATA_W +: DATA_W];
                  res_req_o  <= 1'b1;
                  err_seen   <= 1'b0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A client withdrawing early is flagged once; the resource cycle still completes.
               if (!req_s[sel_o] && !err_seen) begin
                  proto_err_o <= 1'b1;
                  err_seen    <= 1'b1;
               end
               if (res_ack_s) begin
                  result_o <= res_result_i;
                  ack_o    <= {{(N-1){1'b0}}, 1'b1} << sel_o;
                  state    <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!req_s[sel_o]) begin
                  ack_o     <= '0;
                  res_req_o <= 1'b0;
                  state     <= ST_REL;
               end
            end
            ST_REL: begin
               if (!res_ack_s) begin
                  ptr   <= next_idx(sel_o);
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// tb/tb_shifter_rr_arbiter.sv - directed self-checking bench for shifter_rr_arbiter
module tb_shifter_rr_arbiter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_i = '0;
   logic [3:0]  ack_o;
   logic [31:0] req_data_i = '0;
   logic [7:0]  result_o;
   logic        res_req_o;
   logic        res_ack_i = 1'b0;
   logic [7:0]  res_data_o;
   logic [7:0]  res_result_i = '0;
   logic [1:0]  sel_o;
   logic        busy_o;
   logic        proto_err_o;

   logic [3:0]  req0 = '0;
   logic [3:0]  ack0;
   logic [31:0] data0 = '0;
   logic [7:0]  result0;
   logic        res_req0;
   logic [7:0]  res_data0;
   logic [1:0]  sel0;
   logic        busy0;
   logic        perr0;

   int total = 0;
   int bad   = 0;

   logic       auto_mode = 1'b0;
   logic [3:0] client_en = '0;
   logic [3:0] persist = '0;
   int         done_cnt [4];
   int         multi_ack = 0;
   logic       prev_rr = 1'b0;
   logic [1:0] gq [$];

   always #5 clk = ~clk;

   shifter_rr_arbiter #(.N(4), .DATA_W(8), .RES_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .ack_o(ack_o), .req_data_i(req_data_i),
      .result_o(result_o), .res_req_o(res_req_o), .res_ack_i(res_ack_i),
      .res_data_o(res_data_o), .res_result_i(res_result_i), .sel_o(sel_o),
      .busy_o(busy_o), .proto_err_o(proto_err_o)
   );

   shifter_rr_arbiter #(.N(4), .DATA_W(8), .RES_W(8), .SYNC_STAGES(0)) dut0 (
      .clk(clk), .reset(reset), .req_i(req0), .ack_o(ack0), .req_data_i(data0),
      .result_o(result0), .res_req_o(res_req0), .res_ack_i(1'b0),
      .res_data_o(res_data0), .res_result_i(8'h00), .sel_o(sel0),
      .busy_o(busy0), .proto_err_o(perr0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      auto_mode    = 1'b0;
      client_en    = '0;
      persist      = '0;
      req_i        = '0;
      res_ack_i    = 1'b0;
      res_result_i = '0;
      reset        = 1'b1;
      tick(2);
      reset        = 1'b0;
      gq.delete();
      for (int i = 0; i < 4; i++) done_cnt[i] = 0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy_o || req_i != 0) && n < 300) begin
         tick(1);
         n++;
      end
      check(tag, 32'(n < 300), 1);
      tick(4);
   endtask

   // Resource: four-phase follower that returns the inverted request data.
   always @(negedge clk) begin
      if (auto_mode) begin
         res_ack_i    = res_req_o;
         res_result_i = res_data_o ^ 8'hFF;
      end
   end

   // Clients: raise when enabled, drop on ack, optionally re-raise once ack has fallen.
   always @(negedge clk) begin
      if (auto_mode) begin
         for (int i = 0; i < N; i++) begin
            if (req_i[i] && ack_o[i]) begin
               check("result", 32'(result_o), 32'(req_data_i[i*8 +: 8] ^ 8'hFF));
               req_i[i] = 1'b0;
               done_cnt[i]++;
               if (!persist[i]) client_en[i] = 1'b0;
            end else if (!req_i[i] && !ack_o[i] && client_en[i]) begin
               req_i[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!$onehot0(ack_o)) multi_ack++;
      if (res_req_o && !prev_rr) gq.push_back(sel_o);
      prev_rr = res_req_o;
   end

   initial begin
      int n;
      int errs;
      for (int i = 0; i < 4; i++) done_cnt[i] = 0;

      // Reset state
      tick(2);
      check("rst_ack", 32'(ack_o), 0);
      check("rst_res_req", 32'(res_req_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_sel", 32'(sel_o), 0);
      reset = 1'b0;

      // Single client with two-stage synchroniser
      req_i      = 4'b0100;
      req_data_i = 32'h13A5_1110;
      tick(2);
      check("single_early", 32'(res_req_o), 0);
      tick(1);
      check("single_res_req", 32'(res_req_o), 1);
      check("single_sel", 32'(sel_o), 2);
      check("single_data", 32'(res_data_o), 32'hA5);
      check("single_busy", 32'(busy_o), 1);
      res_ack_i    = 1'b1;
      res_result_i = 8'h3C;
      tick(2);
      check("single_ack_early", 32'(ack_o), 0);
      tick(1);
      check("single_ack", 32'(ack_o), 32'b0100);
      check("single_result", 32'(result_o), 32'h3C);
      req_i = '0;
      tick(2);
      check("single_ack_hold", 32'(ack_o), 32'b0100);
      tick(1);
      check("single_ack_drop", 32'(ack_o), 0);
      check("single_rr_drop", 32'(res_req_o), 0);
      check("single_rel_busy", 32'(busy_o), 1);
      res_ack_i = 1'b0;
      tick(3);
      check("single_idle", 32'(busy_o), 0);
      check("single_ptr", 32'(dut.ptr), 3);
      check("single_sel_hold", 32'(sel_o), 2);
      check("single_data_hold", 32'(res_data_o), 32'hA5);

      // Contention: all four persistent
      do_reset();
      req_data_i = 32'h4030_2010;
      auto_mode  = 1'b1;
      client_en  = 4'b1111;
      persist    = 4'b1111;
      n = 0;
      while (gq.size() < 5 && n < 600) begin tick(1); n++; end
      check("cont_timeout", 32'(n < 600), 1);
      client_en = '0;
      persist   = '0;
      wait_idle("cont_idle");
      if (gq.size() >= 5) begin
         check("cont_g0", 32'(gq[0]), 0);
         check("cont_g1", 32'(gq[1]), 1);
         check("cont_g2", 32'(gq[2]), 2);
         check("cont_g3", 32'(gq[3]), 3);
         check("cont_g4", 32'(gq[4]), 0);
      end
      check("cont_onehot", 32'(multi_ack), 0);

      // Wrap and fairness
      do_reset();
      auto_mode = 1'b1;
      client_en = 4'b1000;
      n = 0;
      while (done_cnt[3] < 1 && n < 300) begin tick(1); n++; end
      check("wrap_timeout", 32'(n < 300), 1);
      wait_idle("wrap_idle");
      check("wrap_ptr", 32'(dut.ptr), 0);
      gq.delete();
      client_en = 4'b1001;
      persist   = 4'b0001;
      n = 0;
      while (gq.size() < 3 && n < 600) begin tick(1); n++; end
      check("fair_timeout", 32'(n < 600), 1);
      client_en = '0;
      persist   = '0;
      wait_idle("fair_idle");
      if (gq.size() >= 3) begin
         check("fair_g0", 32'(gq[0]), 0);
         check("fair_g1", 32'(gq[1]), 3);
         check("fair_g2", 32'(gq[2]), 0);
      end

      // Protocol error
      do_reset();
      req_i      = 4'b0001;
      req_data_i = 32'h0000_0077;
      tick(3);
      check("perr_grant", 32'(res_req_o), 1);
      req_i = '0;
      errs = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (proto_err_o) errs++;
      end
      check("perr_pulses", 32'(errs), 1);
      check("perr_no_abort", 32'(res_req_o), 1);
      res_ack_i    = 1'b1;
      res_result_i = 8'h5A;
      tick(3);
      check("perr_ack", 32'(ack_o), 32'b0001);
      check("perr_result", 32'(result_o), 32'h5A);
      check("perr_no_repulse", 32'(proto_err_o), 0);
      tick(1);
      check("perr_ack_drop", 32'(ack_o), 0);
      res_ack_i = 1'b0;
      tick(3);
      check("perr_idle", 32'(busy_o), 0);
      check("perr_ptr", 32'(dut.ptr), 1);

      // Reset mid-transaction
      do_reset();
      req_i      = 4'b0010;
      req_data_i = 32'h0000_C300;
      tick(3);
      res_ack_i    = 1'b1;
      res_result_i = 8'h99;
      tick(3);
      check("mid_ack", 32'(ack_o), 32'b0010);
      reset = 1'b1;
      #1;
      check("mid_rst_ack", 32'(ack_o), 0);
      check("mid_rst_rr", 32'(res_req_o), 0);
      check("mid_rst_busy", 32'(busy_o), 0);
      check("mid_rst_result", 32'(result_o), 0);
      check("mid_rst_sel", 32'(sel_o), 0);
      tick(1);
      reset     = 1'b0;
      req_i     = '0;
      res_ack_i = 1'b0;
      tick(1);
      check("mid_ptr", 32'(dut.ptr), 0);
      req_i = 4'b0010;
      tick(3);
      check("mid_regrant", 32'(res_req_o), 1);
      check("mid_regrant_sel", 32'(sel_o), 1);
      check("mid_regrant_data", 32'(res_data_o), 32'hC3);

      // Unsynchronised variant
      req0  = 4'b0100;
      data0 = 32'h00A5_0000;
      check("s0_before", 32'(res_req0), 0);
      tick(1);
      check("s0_res_req", 32'(res_req0), 1);
      check("s0_sel", 32'(sel0), 2);
      check("s0_data", 32'(res_data0), 32'hA5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shifter_rr_arbiter.md
Name: shifter_rr_arbiter

Overview:
- Clocked round-robin arbiter that shares one four-phase (return-to-zero) shifter/datapath channel among N requesting channels.
- Sits between N client handshake ports and the single shared resource port.
- Synchronises incoming req/ack wires, selects a winner, forwards its bundled data, returns the result and completes both four-phase handshakes before the next grant.
- Clocked counterpart of the gate-level mutex structures used for sharing in the asynchronous examples.

Parameters:
- N, 4, number of requesting channels (2..16).
- DATA_W, 8, bundled request data width per client.
- RES_W, 8, result width returned by the resource.
- SYNC_STAGES, 2, flop stages on req_i and res_ack_i (0 = no synchroniser, inputs used directly).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  N  client four-phase requests.
- ack_o  output  N  client acknowledges, at most one bit high (one-hot or zero).
- req_data_i  input  N*DATA_W  client bundled data, slice i = [i*DATA_W +: DATA_W], stable while req_i[i] high.
- result_o  output  RES_W  result for the currently acknowledged client, valid while its ack_o bit is high.
- res_req_o  output  1  request to shared resource.
- res_ack_i  input  1  resource acknowledge.
- res_data_o  output  DATA_W  data forwarded to resource, stable while res_req_o high.
- res_result_i  input  RES_W  resource result, valid while res_ack_i high.
- sel_o  output  clog2(N)  index of current winner.
- busy_o  output  1  high when state is not IDLE.
- proto_err_o  output  1  one-cycle pulse on a client protocol violation.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all outputs 0; state IDLE; round-robin pointer ptr = 0; synchroniser flops 0.
  - Reset mid-transaction drops res_req_o and ack_o at once; no handshake completion is attempted.
- req_s / res_ack_s are the synchronised inputs.
  - Edge k is the first edge sampling req_i = 1. req_s is visible to the FSM after edge k+SYNC_STAGES-1.
  - With SYNC_STAGES = 0, req_s = req_i.
- FSM states: IDLE, REQ, ACK, REL. Each transition below happens on a clock edge.
- IDLE:
  - If req_s is nonzero, winner = first set index scanning ptr, ptr+1, ... cyclically mod N.
  - Register sel_o = winner and res_data_o = req_data_i[winner slice]; set res_req_o = 1; go to REQ.
  - Resulting latency: res_req_o is high after edge k+SYNC_STAGES.
- REQ:
  - When res_ack_s = 1: register result_o = res_result_i, set ack_o[sel_o] = 1, go to ACK.
  - If req_s[sel_o] = 0 while in REQ: pulse proto_err_o for 1 cycle and keep waiting. The transaction is never aborted.
- ACK:
  - When req_s[sel_o] = 0: clear ack_o[sel_o] and res_req_o in the same edge, go to REL.
- REL:
  - When res_ack_s = 0: ptr = (sel_o+1) mod N, go to IDLE.
  - No new grant is issued before the resource has returned to zero.
- Fairness:
  - The just-served client has lowest priority on the next decision.
  - Requests arriving during a transaction wait. No requester is served twice while another is pending.
- Simultaneous requests are resolved purely by ptr order.
- ptr wraps from N-1 to 0.
- Persistent clients:
  - A client that raises req again right after its ack falls is treated as a new request.
  - With a single active client, back-to-back service has minimum spacing of REL + IDLE = 2 cycles plus synchroniser delay.
- Held-low inputs: res_ack_i stuck low leaves the FSM in REQ indefinitely (no timeout). busy_o stays 1.
- sel_o and res_data_o hold their values after return to IDLE until the next grant.

Decomposition:
- Package shifter_arb_pkg: FSM state enum (IDLE, REQ, ACK, REL); clog2-based index width function; N range checks.
- Sub-module hs_sync: parameterised W-bit, SYNC_STAGES-deep synchroniser with asynchronous reset to 0, bypass when SYNC_STAGES = 0.
  - Instantiated once for req_i (W = N) and once for res_ack_i (W = 1).
- Priority-rotate winner selection stays inline as a function in the top module.

Test Plan:
- Single client: N=4, SYNC_STAGES=2; req_i=4'b0100, req_data_i slice2=8'hA5 at edge 0.
  - Expect res_req_o=1, sel_o=2, res_data_o=8'hA5 after edge 2.
  - Resource returns res_ack_i=1, res_result_i=8'h3C; expect ack_o=4'b0100 and result_o=8'h3C two edges later.
  - Client drops req, resource drops ack; expect IDLE and ptr=3.
- Contention: req_i=4'b1111 held, resource acks each request 1 cycle after res_req_o.
  - Expect grant order 0,1,2,3,0 and never more than one ack_o bit high.
- Wrap and fairness: after serving 3 (ptr=0), raise req_i=4'b1001.
  - Expect grant to 0 then 3. Re-raising req 0 immediately must not preempt a pending 3.
- Protocol error: drop req_i[sel] while in REQ.
  - Expect a single one-cycle proto_err_o pulse; transaction still completes after res_ack_i.
- Reset mid-operation: assert reset while in ACK with ack_o=4'b0010.
  - Expect all outputs 0 within the same cycle (asynchronous) and ptr=0 after release.
  - Next req_i=4'b0010 gets granted.
- SYNC_STAGES=0 variant: req_i rises before edge 0; expect res_req_o=1 after edge 0.
